// File: rtl/capacitor_envelope_vca_pkg.sv
// Shared types and constants for the capacitor envelope VCA: envelope states,
// Q1.15 full scale and the audio sample width.
package capacitor_envelope_vca_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHARGE    = 2'd1,
    HOLD      = 2'd2,
    DISCHARGE = 2'd3
  } env_state_t;

  localparam int AUDIO_W = 16;
  localparam logic [16:0] ENV_MAX = 17'd32767;

  // A step of zero would stall the RC curve short of its rail.
  function automatic logic [16:0] min_step(input logic [16:0] x);
    if (x == 17'd0) begin
      return 17'd1;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/capacitor_envelope_vca_envelope_rc_stepper.sv
// RC-style attack/hold/decay state machine owning the Q1.15 envelope register;
// everything advances only on sample strobes.
module envelope_rc_stepper
  import capacitor_envelope_vca_pkg::*;
#(
  parameter int ATTACK_SHIFT = 4,
  parameter int DECAY_SHIFT  = 6
) (
  input  logic               clk,
  input  logic               I_RSTn,
  input  logic               i_step,
  input  logic               i_gate,
  output logic [AUDIO_W-1:0] o_env,
  output logic               o_busy
);

  env_state_t         r_state;
  env_state_t         w_state_nxt;
  logic [AUDIO_W-1:0] r_env;
  logic [AUDIO_W-1:0] w_env_nxt;
  logic               r_busy;
  logic [16:0]        w_env17;
  logic [16:0]        w_inc;
  logic [16:0]        w_sum;
  logic [16:0]        w_charged;
  logic [16:0]        w_dec;
  logic [16:0]        w_discharged;

  assign w_env17      = {1'b0, r_env};
  assign w_inc        = min_step((ENV_MAX - w_env17) >> ATTACK_SHIFT);
  assign w_sum        = w_env17 + w_inc;
  assign w_charged    = (w_sum > ENV_MAX) ? ENV_MAX : w_sum;
  assign w_dec        = min_step(w_env17 >> DECAY_SHIFT);
  assign w_discharged = (w_env17 > w_dec) ? (w_env17 - w_dec) : 17'd0;

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      r_state <= IDLE;
      r_env   <= 16'd0;
      r_busy  <= 1'b0;
    end else if (i_step) begin
      r_state <= w_state_nxt;
      r_env   <= w_env_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  // Gate tests win over rail arrival so a release at full charge still decays.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (i_gate) w_state_nxt = CHARGE; else w_state_nxt = IDLE;
      CHARGE:    if (!i_gate) w_state_nxt = DISCHARGE;
                 else if (w_charged == ENV_MAX) w_state_nxt = HOLD;
                 else w_state_nxt = CHARGE;
      HOLD:      if (!i_gate) w_state_nxt = DISCHARGE; else w_state_nxt = HOLD;
      DISCHARGE: if (i_gate) w_state_nxt = CHARGE;
                 else if (w_discharged == 17'd0) w_state_nxt = IDLE;
                 else w_state_nxt = DISCHARGE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Gate-driven transitions freeze env for one strobe; rail arrival does not.
  always_comb begin
    w_env_nxt = r_env;
    case (r_state)
      IDLE:      w_env_nxt = 16'd0;
      CHARGE:    if (i_gate) w_env_nxt = w_charged[15:0]; else w_env_nxt = r_env;
      HOLD:      w_env_nxt = ENV_MAX[15:0];
      DISCHARGE: if (!i_gate) w_env_nxt = w_discharged[15:0]; else w_env_nxt = r_env;
      default:   w_env_nxt = 16'd0;
    endcase
  end

  assign o_env  = r_env;
  assign o_busy = r_busy;

endmodule

// File: rtl/capacitor_envelope_vca.sv
// Capacitor envelope VCA: gates an oscillator sample through an RC envelope and
// registers the Q1.15 product once per audio strobe.
module capacitor_envelope_vca
  import capacitor_envelope_vca_pkg::*;
#(
  parameter int SAMPLE_RATE  = 48000,
  parameter int ATTACK_SHIFT = 4,
  parameter int DECAY_SHIFT  = 6
) (
  input  logic                      clk,
  input  logic                      I_RSTn,
  input  logic                      audio_clk_en,
  input  logic                      gate,
  input  logic signed [AUDIO_W-1:0] in,
  output logic signed [AUDIO_W-1:0] out,
  output logic        [AUDIO_W-1:0] env,
  output logic                      busy
);

  if (SAMPLE_RATE < 1 || ATTACK_SHIFT < 0 || ATTACK_SHIFT > 15 ||
      DECAY_SHIFT < 0 || DECAY_SHIFT > 15) begin : g_param_check
    $error("capacitor_envelope_vca: illegal parameter value");
  end

  logic signed [30:0]        w_in_x;
  logic signed [30:0]        w_env_x;
  logic signed [AUDIO_W-1:0] w_vca;
  logic signed [AUDIO_W-1:0] r_out;

  envelope_rc_stepper #(
    .ATTACK_SHIFT(ATTACK_SHIFT),
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_stepper (
    .clk   (clk),
    .I_RSTn(I_RSTn),
    .i_step(audio_clk_en),
    .i_gate(gate),
    .o_env (env),
    .o_busy(busy)
  );

  // env <= 32767 keeps |in*env| below 2^30, so 31 bits hold the exact product.
  assign w_in_x  = {{15{in[AUDIO_W-1]}}, in};
  assign w_env_x = {15'd0, env};
  assign w_vca   = 16'((w_in_x * w_env_x) >>> 15);

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      r_out <= 16'sd0;
    end else if (audio_clk_en) begin
      r_out <= w_vca;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_capacitor_envelope_vca.sv
// Scoreboard bench: the driver pushes reference-model results per strobe and a
// monitor compares them with the DUT one cycle later.
module tb_capacitor_envelope_vca;

  localparam int AS   = 2;
  localparam int DS   = 2;
  localparam int FULL = 32767;

  logic               clk = 1'b0;
  logic               I_RSTn;
  logic               audio_clk_en;
  logic               gate;
  logic signed [15:0] in;
  logic signed [15:0] out;
  logic        [15:0] env;
  logic               busy;

  always #5 clk = ~clk;

  capacitor_envelope_vca #(
    .SAMPLE_RATE (48000),
    .ATTACK_SHIFT(AS),
    .DECAY_SHIFT (DS)
  ) dut (
    .clk         (clk),
    .I_RSTn      (I_RSTn),
    .audio_clk_en(audio_clk_en),
    .gate        (gate),
    .in          (in),
    .out         (out),
    .env         (env),
    .busy        (busy)
  );

  typedef struct {
    int env;
    int out;
    int busy;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: 0 idle, 1 charging, 2 holding at full scale, 3 discharging.
  int m_phase = 0;
  int m_env   = 0;
  int m_out   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int rand_sample();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  function automatic void model_strobe(input int g, input int x);
    exp_t e;
    int   step;
    m_out = (x * m_env) >>> 15;
    case (m_phase)
      0: if (g != 0) m_phase = 1;
      1: if (g == 0) m_phase = 3;
         else begin
           step = (FULL - m_env) >> AS;
           if (step < 1) step = 1;
           m_env = m_env + step;
           if (m_env >= FULL) begin m_env = FULL; m_phase = 2; end
         end
      2: if (g == 0) m_phase = 3;
      3: if (g != 0) m_phase = 1;
         else begin
           step = m_env >> DS;
           if (step < 1) step = 1;
           m_env = m_env - step;
           if (m_env <= 0) begin m_env = 0; m_phase = 0; end
         end
      default: m_phase = 0;
    endcase
    e.env  = m_env;
    e.out  = m_out;
    e.busy = (m_phase != 0) ? 1 : 0;
    sb.push_back(e);
  endfunction

  task automatic drive(input bit en, input bit g, input int x);
    @(posedge clk);
    #2;
    audio_clk_en = en;
    gate         = g;
    in           = x[15:0];
    if (en) model_strobe(int'(g), x);
  endtask

  // Monitor: a strobe seen at a rising edge is checked at the following falling edge.
  initial begin
    bit   pend;
    exp_t e;
    forever begin
      @(posedge clk);
      pend = (audio_clk_en === 1'b1) && (I_RSTn === 1'b1);
      @(negedge clk);
      if (pend) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got strobe with empty queue, expected a queued result");
        end else begin
          e = sb.pop_front();
          check("env", int'(env), e.env);
          check("out", int'(out), e.out);
          check("busy", int'(busy), e.busy);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic reset_and_check(input string name);
    drive(1'b0, 1'b0, 0);
    @(posedge clk);
    #2;
    I_RSTn = 1'b0;
    #1;
    check({name, "_env"}, int'(env), 0);
    check({name, "_out"}, int'(out), 0);
    check({name, "_busy"}, int'(busy), 0);
    m_phase = 0;
    m_env   = 0;
    m_out   = 0;
    repeat (2) @(posedge clk);
    #2;
    I_RSTn = 1'b1;
  endtask

  initial begin
    int n;
    bit g;
    int attack_tbl[3];
    attack_tbl[0] = 8191;
    attack_tbl[1] = 14335;
    attack_tbl[2] = 18943;
    I_RSTn = 1'b0;
    audio_clk_en = 1'b0;
    gate = 1'b0;
    in = 16'sd0;
    repeat (3) @(posedge clk);
    #1;
    check("por_env", int'(env), 0);
    check("por_out", int'(out), 0);
    check("por_busy", int'(busy), 0);
    @(posedge clk);
    #2;
    I_RSTn = 1'b1;

    // Attack from IDLE, checking the early curve against fixed values.
    n = 0;
    while (m_phase != 2 && n < 200) begin
      drive(1'b1, 1'b1, rand_sample());
      drive(1'b0, 1'b1, 0);
      if (n >= 1 && n <= 3) check("attack_curve", int'(env), attack_tbl[n-1]);
      n++;
    end
    check("hold_env", int'(env), FULL);
    check("hold_busy", int'(busy), 1);

    // VCA rails at full envelope.
    drive(1'b1, 1'b1, 16384);
    drive(1'b1, 1'b1, -16384);
    drive(1'b1, 1'b1, -32768);
    drive(1'b1, 1'b1, 32767);
    drive(1'b0, 1'b1, 0);

    // Decay to IDLE.
    n = 0;
    while (m_phase != 0 && n < 400) begin
      drive(1'b1, 1'b0, rand_sample());
      n++;
    end
    drive(1'b1, 1'b0, -32768);
    drive(1'b1, 1'b0, 32767);
    drive(1'b0, 1'b0, 0);
    check("idle_busy", int'(busy), 0);

    // Retrigger during decay must resume from the current level.
    n = 0;
    while (!(m_phase == 1 && m_env == 14335) && n < 50) begin
      drive(1'b1, 1'b1, rand_sample());
      n++;
    end
    n = 0;
    while (!(m_phase == 3 && m_env == 10752) && n < 50) begin
      drive(1'b1, 1'b0, rand_sample());
      n++;
    end
    drive(1'b1, 1'b1, rand_sample());
    drive(1'b0, 1'b1, 0);
    check("retrig_env", int'(env), 10752);
    drive(1'b1, 1'b1, rand_sample());
    drive(1'b0, 1'b1, 0);

    // Back to IDLE, then a gate pulse entirely between strobes.
    n = 0;
    while (m_phase != 0 && n < 400) begin
      drive(1'b1, 1'b0, rand_sample());
      n++;
    end
    drive(1'b0, 1'b1, 0);
    drive(1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, rand_sample());
    drive(1'b0, 1'b0, 0);
    check("pulse_busy", int'(busy), 0);

    // Mid-charge, then no strobes for 1000 cycles while gate and in wander.
    repeat (3) drive(1'b1, 1'b1, rand_sample());
    for (int i = 0; i < 1000; i++) begin
      drive(1'b0, 1'($urandom_range(1)), rand_sample());
      if (i % 250 == 249) begin
        check("frozen_env", int'(env), m_env);
        check("frozen_out", int'(out), m_out);
        check("frozen_busy", int'(busy), (m_phase != 0) ? 1 : 0);
      end
    end

    // Asynchronous reset in CHARGE at env 14335.
    n = 0;
    while (!(m_phase == 1 && m_env == 14335) && n < 500) begin
      drive(1'b1, (m_phase == 0 || m_phase == 1) ? 1'b1 : 1'b0, rand_sample());
      n++;
    end
    check("pre_reset_env", int'(env), 14335);
    reset_and_check("midreset");

    // Random gate runs, strobe spacing and samples.
    g = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(24) == 0) g = ~g;
      drive(($urandom_range(2) == 0) ? 1'b1 : 1'b0, g, rand_sample());
    end

    repeat (3) drive(1'b0, 1'b0, 0);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
